// File: rtl/crc32_check_rx8.sv
`default_nettype none
// ============================================================================
//  Module   : crc32_check_rx8
//  Purpose  : Byte-wide Ethernet receive FCS checker; strips the 4 FCS bytes
//             and reports CRC-32 status and payload length per frame.
//  Revision : 1.0 - initial release
// ============================================================================
module crc32_check_rx8 #(
    parameter int LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_dv,
    input  logic [7:0]       i_data_in,
    output logic             o_dv,
    output logic [7:0]       o_data_out,
    output logic             o_frame_done,
    output logic             o_crc_ok,
    output logic             o_crc_err,
    output logic             o_runt,
    output logic [LEN_W-1:0] o_len
);

    localparam logic [31:0]      C_POLY    = 32'h04C11DB7;
    localparam logic [31:0]      C_SEED    = 32'hFFFF_FFFF;
    localparam logic [31:0]      C_RESIDUE = 32'hC704_DD7B;
    localparam logic [LEN_W-1:0] C_LEN_MAX = {LEN_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t           state_q;
    logic [31:0]      crc_q;
    logic [31:0]      crc_d;
    logic [2:0]       cnt_q;
    logic [7:0]       dl_q [4];
    logic [LEN_W-1:0] pay_q;
    logic [LEN_W-1:0] pay_d;

    // MSB-first CRC fed LSB of the byte first, i.e. bit-reversed input.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = {r[30:0], 1'b0} ^ (((r[31] ^ d[i]) == 1'b1) ? C_POLY : 32'h0);
        end
        return r;
    endfunction

    always_comb begin
        crc_d = crc_byte((state_q == S_IDLE) ? C_SEED : crc_q, i_data_in);
        pay_d = (pay_q == C_LEN_MAX) ? pay_q : pay_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            crc_q        <= C_SEED;
            cnt_q        <= 3'd0;
            pay_q        <= '0;
            for (int i = 0; i < 4; i++) dl_q[i] <= 8'h00;
            o_dv         <= 1'b0;
            o_data_out   <= 8'h00;
            o_frame_done <= 1'b0;
            o_crc_ok     <= 1'b0;
            o_crc_err    <= 1'b0;
            o_runt       <= 1'b0;
            o_len        <= '0;
        end else begin
            o_dv         <= 1'b0;
            o_data_out   <= 8'h00;
            o_frame_done <= 1'b0;
            o_crc_ok     <= 1'b0;
            o_crc_err    <= 1'b0;
            o_runt       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_dv) begin
                        state_q <= S_FILL;
                        crc_q   <= crc_d;
                        cnt_q   <= 3'd1;
                        dl_q[0] <= i_data_in;
                        for (int i = 1; i < 4; i++) dl_q[i] <= dl_q[i-1];
                    end
                end
                S_FILL, S_STREAM: begin
                    if (i_dv) begin
                        crc_q   <= crc_d;
                        dl_q[0] <= i_data_in;
                        for (int i = 1; i < 4; i++) dl_q[i] <= dl_q[i-1];
                        // The oldest delay-line byte leaves once five bytes are in.
                        if (state_q == S_STREAM || cnt_q == 3'd4) begin
                            state_q    <= S_STREAM;
                            o_dv       <= 1'b1;
                            o_data_out <= dl_q[3];
                            pay_q      <= pay_d;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end else begin
                        state_q      <= S_IDLE;
                        o_frame_done <= 1'b1;
                        o_runt       <= (state_q == S_FILL);
                        o_crc_ok     <= (state_q == S_STREAM) && (crc_q == C_RESIDUE);
                        o_crc_err    <= (state_q == S_FILL) || (crc_q != C_RESIDUE);
                        o_len        <= (state_q == S_STREAM) ? pay_q : '0;
                        crc_q        <= C_SEED;
                        cnt_q        <= 3'd0;
                        pay_q        <= '0;
                        for (int i = 0; i < 4; i++) dl_q[i] <= 8'h00;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
